ps2_mouse_packet_decoder: RTL and testbench

//   Consumes the byte stream produced by the PS/2 receiver (PS2_comm) and assembles standard
//   3-byte PS/2 mouse packets. Maintains an absolute cursor position and button states.

---
 rtl/ps2_mouse_packet_decoder.sv | 230 +++++++++++++++++++++++
 tb/tb_ps2_mouse_packet_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_packet_decoder.sv
// ps2_mouse_packet_decoder
//   Assembles 3-byte PS/2 mouse packets from the receiver byte stream and keeps
//   an absolute cursor position plus button states.
//   The optional MOUSE_WRAP_EN macro makes the cursor wrap around the screen
//   edges instead of saturating at them. The default build (macro undefined)
//   saturates.
//   Every output comes straight from a register. Cursor, buttons and
//   packet_valid change together, one cycle after the byte_valid that
//   delivered the third byte.
module ps2_mouse_packet_decoder #(
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_err,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic       packet_valid,
  output logic       sync_err
);

  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [9:0] LP_X_MAX = 10'(X_MAX);
  localparam logic [9:0] LP_Y_MAX = 10'(Y_MAX);
  localparam logic [9:0] LP_X_INI = 10'(X_INIT);
  localparam logic [9:0] LP_Y_INI = 10'(Y_INIT);
  localparam logic [TW-1:0] LP_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2,
    UPDATE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [TW-1:0]       r_tmo;
  logic [2:0]          r_hdr_btn;
  logic                r_x_sign;
  logic                r_y_sign;
  logic                r_x_ovf;
  logic                r_y_ovf;
  logic [7:0]          r_dx;
  logic [9:0]          r_cursor_x;
  logic [9:0]          r_cursor_y;
  logic [2:0]          r_btn;
  logic                r_packet_valid;
  logic                r_sync_err;

  logic                w_hdr_ok;
  logic                w_dx_ok;
  logic                w_dy_ok;
  logic                w_sync;
  logic                w_tmo_hit;
  logic signed [11:0]  w_delta_x;
  logic signed [11:0]  w_delta_y;
  logic [9:0]          w_new_x;
  logic [9:0]          w_new_y;

  // Adds a signed delta to one axis and folds the result back into [0, maxv].
  // The largest delta is 256 in magnitude, so one correction step is enough
  // when wrapping.
  function automatic logic [9:0] axis_step(input logic [9:0] cur,
                                           input logic signed [11:0] delta,
                                           input logic [9:0] maxv);
    logic signed [11:0] sum;
    logic signed [11:0] lim;
    lim = $signed({2'b00, maxv});
    sum = $signed({2'b00, cur}) + delta;
`ifdef MOUSE_WRAP_EN
    if (sum < 12'sd0) begin
      sum = sum + lim + 12'sd1;
    end else if (sum > lim) begin
      sum = sum - lim - 12'sd1;
    end
`else
    if (sum < 12'sd0) begin
      sum = 12'sd0;
    end else if (sum > lim) begin
      sum = lim;
    end
`endif
    return 10'(sum);
  endfunction

  assign w_tmo_hit = (r_tmo == LP_TMO_LAST);

  // Both deltas are 9-bit signed values, {sign, byte}. An axis whose overflow
  // bit is set contributes no motion. PS/2 +Y points up, but the screen Y
  // axis grows downward, so the Y delta is negated.
  assign w_delta_x = r_x_ovf ? 12'sd0 : $signed({{3{r_x_sign}}, r_x_sign, r_dx});
  assign w_delta_y = r_y_ovf ? 12'sd0 : -$signed({{3{r_y_sign}}, r_y_sign, byte_data});
  assign w_new_x   = axis_step(r_cursor_x, w_delta_x, LP_X_MAX);
  assign w_new_y   = axis_step(r_cursor_y, w_delta_y, LP_Y_MAX);

  // Next-state logic. A receiver error overrides everything else, and any
  // byte_valid in the same cycle is ignored.
  always_comb begin
    w_state_next = r_state;
    w_hdr_ok     = 1'b0;
    w_dx_ok      = 1'b0;
    w_dy_ok      = 1'b0;
    w_sync       = 1'b0;
    if (byte_err) begin
      w_state_next = WAIT_B0;
      w_sync       = 1'b1;
    end else begin
      unique case (r_state)
        WAIT_B0: begin
          if (byte_valid) begin
            if (byte_data[3]) begin
              w_hdr_ok     = 1'b1;
              w_state_next = WAIT_B1;
            end else begin
              w_sync = 1'b1;
            end
          end
        end
        WAIT_B1: begin
          if (byte_valid) begin
            w_dx_ok      = 1'b1;
            w_state_next = WAIT_B2;
          end else if (w_tmo_hit) begin
            w_sync       = 1'b1;
            w_state_next = WAIT_B0;
          end
        end
        WAIT_B2: begin
          if (byte_valid) begin
            w_dy_ok      = 1'b1;
            w_state_next = UPDATE;
          end else if (w_tmo_hit) begin
            w_sync       = 1'b1;
            w_state_next = WAIT_B0;
          end
        end
        UPDATE: begin
          w_state_next = WAIT_B0;
        end
        default: begin
          w_state_next = WAIT_B0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_B0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Inter-byte timeout counter. It counts idle cycles inside a packet and
  // clears whenever the state changes, which covers accepted bytes and aborts.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
    end else if ((r_state == WAIT_B1 || r_state == WAIT_B2) && (w_state_next == r_state)) begin
      r_tmo <= r_tmo + TW'(1);
    end else begin
      r_tmo <= '0;
    end
  end

  // Holds the header fields and the X byte of the packet in progress.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      r_hdr_btn <= 3'b000;
      r_x_sign  <= 1'b0;
      r_y_sign  <= 1'b0;
      r_x_ovf   <= 1'b0;
      r_y_ovf   <= 1'b0;
      r_dx      <= 8'h00;
    end else begin
      if (w_hdr_ok) begin
        r_hdr_btn <= byte_data[2:0];
        r_x_sign  <= byte_data[4];
        r_y_sign  <= byte_data[5];
        r_x_ovf   <= byte_data[6];
        r_y_ovf   <= byte_data[7];
      end
      if (w_dx_ok) begin
        r_dx <= byte_data;
      end
    end
  end

  // Updates cursor and buttons when the third byte arrives. The following
  // cycle is the UPDATE state, in which the new values and packet_valid are
  // visible.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      r_cursor_x     <= LP_X_INI;
      r_cursor_y     <= LP_Y_INI;
      r_btn          <= 3'b000;
      r_packet_valid <= 1'b0;
      r_sync_err     <= 1'b0;
    end else begin
      r_packet_valid <= w_dy_ok;
      r_sync_err     <= w_sync;
      if (w_dy_ok) begin
        r_cursor_x <= w_new_x;
        r_cursor_y <= w_new_y;
        r_btn      <= r_hdr_btn;
      end
    end
  end

  assign cursor_x     = r_cursor_x;
  assign cursor_y     = r_cursor_y;
  assign btn_left     = r_btn[0];
  assign btn_right    = r_btn[1];
  assign btn_middle   = r_btn[2];
  assign packet_valid = r_packet_valid;
  assign sync_err     = r_sync_err;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Testbench for ps2_mouse_packet_decoder: directed cases, then randomized
// packets checked against a behavioural cursor model.
// The model follows MOUSE_WRAP_EN in the same way the design does.
module tb_ps2_mouse_packet_decoder;

  localparam int TMO = 40;
  localparam int XM  = 639;
  localparam int YM  = 479;

  logic       qzt_clk = 1'b0;
  logic       reset = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_err = 1'b0;
  logic [9:0] cursor_x;
  logic [9:0] cursor_y;
  logic       btn_left;
  logic       btn_right;
  logic       btn_middle;
  logic       packet_valid;
  logic       sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: expected cursor position and button states.
  int         mx;
  int         my;
  logic [2:0] mb;

  ps2_mouse_packet_decoder #(
    .X_MAX(XM), .Y_MAX(YM), .X_INIT(320), .Y_INIT(240), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .qzt_clk(qzt_clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_err(byte_err), .cursor_x(cursor_x), .cursor_y(cursor_y), .btn_left(btn_left),
    .btn_right(btn_right), .btn_middle(btn_middle), .packet_valid(packet_valid),
    .sync_err(sync_err)
  );

  always #5 qzt_clk = ~qzt_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int axis(input int cur, input int d, input int maxv);
    int s;
    s = cur + d;
`ifdef MOUSE_WRAP_EN
    if (s < 0) s = s + maxv + 1;
    else if (s > maxv) s = s - (maxv + 1);
`else
    if (s < 0) s = 0;
    else if (s > maxv) s = maxv;
`endif
    return s;
  endfunction

  // Applies one complete packet to the reference state.
  task automatic model_packet(input logic [7:0] h, input logic [7:0] bx, input logic [7:0] by);
    int dx;
    int dy;
    dx = h[6] ? 0 : (h[4] ? int'(bx) - 256 : int'(bx));
    dy = h[7] ? 0 : (h[5] ? int'(by) - 256 : int'(by));
    mx = axis(mx, dx, XM);
    my = axis(my, -dy, YM);
    mb = h[2:0];
  endtask

  // Compares all outputs with the reference state and the expected strobes.
  task automatic chk_all(input string tag, input logic pv, input logic se);
    chk({tag, ".x"}, int'(cursor_x), mx);
    chk({tag, ".y"}, int'(cursor_y), my);
    chk({tag, ".btn"}, int'({btn_middle, btn_right, btn_left}), int'(mb));
    chk({tag, ".pv"}, int'(packet_valid), int'(pv));
    chk({tag, ".se"}, int'(sync_err), int'(se));
  endtask

  // Returns one negedge after the cycle in which the byte was presented,
  // which is where the registered response becomes visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge qzt_clk);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge qzt_clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_err(input logic with_byte, input logic [7:0] b);
    @(negedge qzt_clk);
    byte_err   = 1'b1;
    byte_valid = with_byte;
    byte_data  = b;
    @(negedge qzt_clk);
    byte_err   = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge qzt_clk);
  endtask

  task automatic do_reset;
    @(negedge qzt_clk);
    reset = 1'b1;
    @(negedge qzt_clk);
    reset = 1'b0;
    mx = 320;
    my = 240;
    mb = 3'b000;
  endtask

  task automatic packet(input string tag, input logic [7:0] h, input logic [7:0] bx,
                        input logic [7:0] by, input int gap);
    send_byte(h);
    chk_all({tag, ".b1"}, 1'b0, 1'b0);
    idle(gap);
    send_byte(bx);
    chk_all({tag, ".b2"}, 1'b0, 1'b0);
    idle(gap);
    send_byte(by);
    model_packet(h, bx, by);
    chk_all(tag, 1'b1, 1'b0);
    $display("pkt %s hdr=%02h dx=%02h dy=%02h -> x=%0d y=%0d btn=%0d", tag, h, bx, by,
             cursor_x, cursor_y, {btn_middle, btn_right, btn_left});
  endtask

  initial begin
    int se_cnt;
    logic [7:0] h;
    logic [7:0] bx;
    logic [7:0] by;
    int mode;

    mx = 320; my = 240; mb = 3'b000;
    idle(3);
    chk_all("reset", 1'b0, 1'b0);
    reset = 1'b0;
    idle(2);
    chk_all("reset_rel", 1'b0, 1'b0);

    // Basic packet: left button, +5 X, +3 up.
    packet("basic", 8'h09, 8'h05, 8'h03, 0);
    chk("basic.xc", int'(cursor_x), 325);
    chk("basic.yc", int'(cursor_y), 237);
    chk("basic.L", int'(btn_left), 1);
    @(negedge qzt_clk);
    chk("basic.pv_drop", int'(packet_valid), 0);

    // Largest negative X step twice: the second step crosses the left edge.
    do_reset();
    packet("neg256a", 8'h18, 8'h00, 8'h00, 1);
    chk("neg256a.xc", int'(cursor_x), 64);
    packet("neg256b", 8'h18, 8'h00, 8'h00, 1);
`ifdef MOUSE_WRAP_EN
    chk("neg256b.xc", int'(cursor_x), 448);
`else
    chk("neg256b.xc", int'(cursor_x), 0);
`endif

    // A header with bit 3 clear is dropped and the decoder stays in sync.
    do_reset();
    send_byte(8'h00);
    chk_all("badhdr", 1'b0, 1'b1);
    packet("after_bad", 8'h08, 8'h01, 8'h01, 0);
    chk("after_bad.xc", int'(cursor_x), 321);
    chk("after_bad.yc", int'(cursor_y), 239);

    // Partial packet followed by a long idle period must time out exactly once.
    send_byte(8'h08);
    send_byte(8'h10);
    se_cnt = 0;
    for (int i = 0; i < TMO + 10; i++) begin
      @(negedge qzt_clk);
      if (sync_err) se_cnt++;
    end
    chk("tmo.pulses", se_cnt, 1);
    chk_all("tmo", 1'b0, 1'b0);
    packet("after_tmo", 8'h0C, 8'h20, 8'hF0, 2);

    // byte_err after the header, and byte_err arriving together with byte 3.
    send_byte(8'h09);
    send_err(1'b0, 8'h00);
    chk_all("err_b1", 1'b0, 1'b1);
    send_byte(8'h09);
    send_byte(8'h11);
    send_err(1'b1, 8'h22);
    chk_all("err_b3", 1'b0, 1'b1);
    packet("after_err", 8'h0A, 8'h07, 8'h09, 0);

    // Overflow on X: X motion is suppressed, Y and buttons still update.
    do_reset();
    packet("xovf", 8'h4A, 8'hFF, 8'h02, 0);
    chk("xovf.xc", int'(cursor_x), 320);
    chk("xovf.yc", int'(cursor_y), 238);
    chk("xovf.R", int'(btn_right), 1);

    // Reset in the middle of a packet takes effect immediately.
    send_byte(8'h09);
    send_byte(8'h05);
    #3 reset = 1'b1;
    #1;
    mx = 320; my = 240; mb = 3'b000;
    chk_all("async_rst", 1'b0, 1'b0);
    @(negedge qzt_clk);
    reset = 1'b0;
    packet("after_rst", 8'h0B, 8'h03, 8'h04, 0);

    // Random traffic: valid packets mixed with bad headers and receiver errors.
    for (int n = 0; n < 200; n++) begin
      h    = 8'($urandom) | 8'h08;
      bx   = 8'($urandom);
      by   = 8'($urandom);
      mode = int'($urandom_range(0, 9));
      if (mode == 0) begin
        send_byte(8'($urandom) & 8'hF7);
        chk_all($sformatf("rnd%0d.bad", n), 1'b0, 1'b1);
      end else if (mode == 1) begin
        send_byte(h);
        send_err($urandom_range(0, 1) == 1, bx);
        chk_all($sformatf("rnd%0d.err", n), 1'b0, 1'b1);
      end
      packet($sformatf("rnd%0d", n), h, bx, by, int'($urandom_range(0, TMO / 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
